// File: rtl/adder_node_arbiter_pkg.sv
// adder_node_arbiter_pkg: shared sizing helpers (clog2, latency derivation, counter width)
package adder_node_arbiter_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int add_lat(input int reg_mid, input int reg_out);
    return reg_mid + reg_out;
  endfunction
  function automatic int total_lat(input int in_reg, input int reg_mid, input int reg_out);
    return in_reg + add_lat(reg_mid, reg_out);
  endfunction
  function automatic int cnt_w(input int lat);
    return clog2(lat + 1) < 1 ? 1 : clog2(lat + 1);
  endfunction
endpackage

// File: rtl/adder_node_arbiter_if.sv
// adder_node_arbiter_if: requester bus (req_valid/req_a/req_b/req_ready) and tagged result bus (res_valid/res_data/inflight)
interface adder_node_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int IN_BITS  = 16,
  parameter int OUT_BITS = 17,
  parameter int CNT_W    = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*IN_BITS-1:0] req_a;
  logic [NUM_REQ*IN_BITS-1:0] req_b;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         res_valid;
  logic [OUT_BITS-1:0]        res_data;
  logic [CNT_W-1:0]           inflight;
  modport master (output req_valid, req_a, req_b, input req_ready, res_valid, res_data, inflight);
  modport slave (input req_valid, req_a, req_b, output req_ready, res_valid, res_data, inflight);
endinterface

// File: rtl/adder_node_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over req starting at the rr pointer; ports clk, rst, req, grant
module rr_arbiter
  import adder_node_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = clog2(N) < 1 ? 1 : clog2(N);
  logic [PW-1:0] ptr, ptr_nxt;
  int idx;
  // Scan from the farthest offset back to offset 0 so the nearest requester after ptr wins.
  always_comb begin
    grant = '0;
    ptr_nxt = ptr;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant = N'(1) << idx;
        ptr_nxt = PW'((idx + 1) % N);
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else ptr <= ptr_nxt;
endmodule

// File: rtl/adder_tree_node.sv
// adder_tree_node: sum = ext(a) + (ext(b) << B_SHIFT) truncated to OUT_BITS; ports clk, a, b, sum; optional middle/output registers
module adder_tree_node #(
  parameter int IN_BITS         = 16,
  parameter int OUT_BITS        = 17,
  parameter int SIGN_EXT        = 1,
  parameter int B_SHIFT         = 0,
  parameter int REGISTER_MIDDLE = 0,
  parameter int REGISTER_OUTPUT = 1
) (
  input  logic                clk,
  input  logic [IN_BITS-1:0]  a,
  input  logic [IN_BITS-1:0]  b,
  output logic [OUT_BITS-1:0] sum
);
  localparam bit SX = SIGN_EXT != 0;
  logic [OUT_BITS-1:0] ax, bx, ax_m, bx_m, sum_c;
  assign ax = {{(OUT_BITS-IN_BITS){SX & a[IN_BITS-1]}}, a};
  assign bx = {{(OUT_BITS-IN_BITS){SX & b[IN_BITS-1]}}, b} << B_SHIFT;
  if (REGISTER_MIDDLE != 0) begin : g_mid
    always_ff @(posedge clk) begin
      ax_m <= ax;
      bx_m <= bx;
    end
  end else begin : g_mid_byp
    assign ax_m = ax;
    assign bx_m = bx;
  end
  assign sum_c = ax_m + bx_m;
  if (REGISTER_OUTPUT != 0) begin : g_out
    always_ff @(posedge clk) sum <= sum_c;
  end else begin : g_out_byp
    assign sum = sum_c;
  end
endmodule

// File: rtl/adder_node_arbiter.sv
// adder_node_arbiter: shares one adder_tree_node among NUM_REQ requesters; ports clk, rst, bus (slave: req_* in, req_ready/res_*/inflight out)
module adder_node_arbiter
  import adder_node_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int IN_BITS         = 16,
  parameter int OUT_BITS        = 17,
  parameter int SIGN_EXT        = 1,
  parameter int B_SHIFT         = 0,
  parameter int REGISTER_MIDDLE = 0,
  parameter int REGISTER_OUTPUT = 1,
  parameter int IN_REG          = 1
) (
  input logic clk,
  input logic rst,
  adder_node_arbiter_if.slave bus
);
  localparam int LAT   = total_lat(IN_REG, REGISTER_MIDDLE, REGISTER_OUTPUT);
  localparam int CNT_W = cnt_w(LAT);
  logic [NUM_REQ-1:0]  grant, res_valid;
  logic [IN_BITS-1:0]  a_sel, b_sel, a_n, b_n;
  logic [OUT_BITS-1:0] sum;
  logic [CNT_W-1:0]    inflight;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (bus.req_valid),
    .grant(grant)
  );
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_sel = grant[i] ? bus.req_a[i*IN_BITS +: IN_BITS] : a_sel;
      b_sel = grant[i] ? bus.req_b[i*IN_BITS +: IN_BITS] : b_sel;
    end
  end
  if (IN_REG != 0) begin : g_in
    always_ff @(posedge clk) begin
      a_n <= a_sel;
      b_n <= b_sel;
    end
  end else begin : g_in_byp
    assign a_n = a_sel;
    assign b_n = b_sel;
  end
  adder_tree_node #(
    .IN_BITS        (IN_BITS),
    .OUT_BITS       (OUT_BITS),
    .SIGN_EXT       (SIGN_EXT),
    .B_SHIFT        (B_SHIFT),
    .REGISTER_MIDDLE(REGISTER_MIDDLE),
    .REGISTER_OUTPUT(REGISTER_OUTPUT)
  ) u_node (
    .clk(clk),
    .a  (a_n),
    .b  (b_n),
    .sum(sum)
  );
  // One-hot owner tags travel alongside the node data; the input-register stage is simply stage 0.
  if (LAT > 0) begin : g_tags
    logic [NUM_REQ-1:0] sr [LAT];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int i = 0; i < LAT; i++) sr[i] <= '0;
        inflight <= '0;
      end else begin
        sr[0] <= grant;
        for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        inflight <= inflight + CNT_W'(|grant) - CNT_W'(|res_valid);
      end
    assign res_valid = sr[LAT-1];
  end else begin : g_tags_byp
    assign res_valid = grant;
    assign inflight = '0;
  end
  assign bus.req_ready = grant;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = sum;
  assign bus.inflight  = inflight;
endmodule

// File: tb/tb_adder_node_arbiter.sv
// tb_adder_node_arbiter: checks a default (LAT=2) and a combinational (LAT=0, B_SHIFT=1, unsigned) instance against a queue model
module tb_adder_node_arbiter;
  import adder_node_arbiter_pkg::*;
  localparam int N = 4, IB = 16, OB = 17;
  localparam int LAT = total_lat(1, 0, 1);
  typedef struct packed {
    logic [N-1:0]  tag;
    logic [OB-1:0] d;
  } ent_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] v = '0;
  logic [N*IB-1:0] ra = '0, rb = '0;
  int vecs = 0, errs = 0, rr = 0;
  ent_t q[$];
  always #5 clk = ~clk;
  adder_node_arbiter_if #(.NUM_REQ(N), .IN_BITS(IB), .OUT_BITS(OB), .CNT_W(cnt_w(LAT))) bus1 ();
  adder_node_arbiter_if #(.NUM_REQ(N), .IN_BITS(IB), .OUT_BITS(OB), .CNT_W(1)) bus2 ();
  assign bus1.req_valid = v;
  assign bus1.req_a = ra;
  assign bus1.req_b = rb;
  assign bus2.req_valid = v;
  assign bus2.req_a = ra;
  assign bus2.req_b = rb;
  adder_node_arbiter #(.NUM_REQ(N), .IN_BITS(IB), .OUT_BITS(OB)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  adder_node_arbiter #(.NUM_REQ(N), .IN_BITS(IB), .OUT_BITS(OB), .SIGN_EXT(0), .B_SHIFT(1),
    .IN_REG(0), .REGISTER_OUTPUT(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic logic [OB-1:0] ref_sum(input logic [IB-1:0] a, input logic [IB-1:0] b, input bit sgn, input int sh);
    longint x, y;
    x = a;
    y = b;
    if (sgn && a[IB-1]) x = x - 65536;
    if (sgn && b[IB-1]) y = y - 65536;
    return OB'(x + (y << sh));
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [N-1:0] vv, input bit keep);
    int g, n;
    logic [N-1:0] oh;
    ent_t e;
    @(posedge clk);
    #1;
    v = vv;
    if (!keep) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
    end
    @(negedge clk);
    g = pick(v, rr);
    oh = g < 0 ? '0 : N'(1) << g;
    e = q.size() == LAT ? q[0] : '0;
    n = 0;
    foreach (q[i]) if (q[i].tag != 0) n++;
    check("ready1", bus1.req_ready, oh);
    check("res_valid1", bus1.res_valid, e.tag);
    if (e.tag != 0) check("res_data1", bus1.res_data, e.d);
    check("inflight1", bus1.inflight, n);
    check("ready2", bus2.req_ready, oh);
    check("res_valid2", bus2.res_valid, oh);
    if (g >= 0) check("res_data2", bus2.res_data, ref_sum(ra[g*IB +: IB], rb[g*IB +: IB], 0, 1));
    check("inflight2", bus2.inflight, 0);
    if (q.size() == LAT) void'(q.pop_front());
    e = '0;
    if (g >= 0) begin
      e.tag = oh;
      e.d = ref_sum(ra[g*IB +: IB], rb[g*IB +: IB], 1, 0);
      rr = (g + 1) % N;
    end
    q.push_back(e);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    v = '0;
    @(negedge clk);
    check("rst_ready", bus1.req_ready, 0);
    check("rst_res_valid", bus1.res_valid, 0);
    check("rst_inflight", bus1.inflight, 0);
    rst = 0;
    q.delete();
    rr = 0;
  endtask
  initial begin
    @(negedge clk);
    check("init_res_valid", bus1.res_valid, 0);
    check("init_inflight", bus1.inflight, 0);
    rst = 0;
    repeat (2) step('0, 0);
    ra = '0;
    rb = '0;
    ra[1*IB +: IB] = 16'h0003;
    rb[1*IB +: IB] = 16'h0004;
    step(4'b0010, 1);
    repeat (4) step('0, 1);
    ra[1*IB +: IB] = 16'hFFFF;
    rb[1*IB +: IB] = 16'hFFFE;
    step(4'b0010, 1);
    repeat (3) step('0, 1);
    ra[2*IB +: IB] = 16'd5;
    rb[2*IB +: IB] = 16'd3;
    step(4'b0100, 1);
    repeat (3) step('0, 1);
    repeat (10) step(4'b1111, 0);
    repeat (3) step(4'b0001, 0);
    repeat (6) step(4'b0101, 0);
    repeat (2) step(4'b1111, 0);
    do_reset();
    step(4'b1111, 0);
    repeat (LAT + 1) step('0, 0);
    repeat (300) step(N'($urandom), 0);
    repeat (LAT + 1) step('0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
